// File: rtl/mem_write_buffer_if.sv
// Avalon-MM bus bundle used on both sides of the posted-write buffer.
// The master drives the request fields; the slave answers with readdata/waitrequest.
interface mem_write_buffer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                write;
  logic                read;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   readdata;
  logic                waitrequest;

  modport master (
    output address, write, read, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/mem_write_buffer.sv
// Posted-write buffer: CPU writes land in a small FIFO and retire in order downstream;
// reads wait for the FIFO to drain, then pass through as one blocking transfer.
module mem_write_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  mem_write_buffer_if.slave  s,
  mem_write_buffer_if.master m,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  output logic [31:0] csr_readdata
);
  localparam int BE_W    = DATA_W / 8;
  localparam int PTR_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W + BE_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W-1:0]   level, level_next;
  logic [31:0]        level_next_w;
  logic               full, empty, push, pop;
  logic               m_write_int, m_read_int;
  logic [ENTRY_W-1:0] head;
  logic [DATA_W-1:0]  s_readdata_reg;
  logic [31:0]        wr_retired_reg, rd_done_reg, max_fill_reg, csr_readdata_reg;

  assign level = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PTR_W-1] != rd_ptr_reg[PTR_W-1]) &&
                 (wr_ptr_reg[PTR_W-2:0] == rd_ptr_reg[PTR_W-2:0]);
  assign head  = fifo_mem[rd_ptr_reg[PTR_W-2:0]];

  // Pushes only in IDLE and never into a full FIFO, even if a pop frees a slot this cycle.
  assign push        = reset_n && (state_reg == ST_IDLE) && s.write && !s.read && !full;
  assign m_write_int = reset_n && (state_reg != ST_READ) && !empty;
  assign m_read_int  = reset_n && (state_reg == ST_READ);
  assign pop         = m_write_int && !m.waitrequest;

  assign level_next   = level + PTR_W'(push) - PTR_W'(pop);
  assign level_next_w = 32'(level_next);

  assign m.write      = m_write_int;
  assign m.read       = m_read_int;
  assign m.address    = (state_reg == ST_READ) ? s.address : head[ENTRY_W-1 -: ADDR_W];
  assign m.writedata  = head[BE_W +: DATA_W];
  assign m.byteenable = (state_reg == ST_READ) ? s.byteenable : head[BE_W-1:0];

  assign s.readdata   = s_readdata_reg;
  assign csr_readdata = csr_readdata_reg;

  always_comb begin
    s.waitrequest = 1'b1;
    if (reset_n) begin
      case (state_reg)
        ST_IDLE: s.waitrequest = !push;
        ST_RESP: s.waitrequest = 1'b0;
        default: s.waitrequest = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (s.read) state_next = empty ? ST_READ : ST_DRAIN;
      // Leave DRAIN right after the pop that empties the FIFO.
      ST_DRAIN: if (empty || (pop && level == PTR_W'(1))) state_next = ST_READ;
      ST_READ:  if (!m.waitrequest) state_next = ST_RESP;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-2:0]] <= {s.address, s.writedata, s.byteenable};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      s_readdata_reg   <= '0;
      wr_retired_reg   <= '0;
      rd_done_reg      <= '0;
      max_fill_reg     <= '0;
      csr_readdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (state_reg == ST_READ && !m.waitrequest) s_readdata_reg <= m.readdata;

      // A clear overrides any increment landing on the same edge.
      if (csr_write) begin
        wr_retired_reg <= '0;
        rd_done_reg    <= '0;
        max_fill_reg   <= '0;
      end else begin
        wr_retired_reg <= wr_retired_reg + 32'(pop);
        rd_done_reg    <= rd_done_reg + 32'(state_reg == ST_RESP);
        if (level_next_w > max_fill_reg) max_fill_reg <= level_next_w;
      end

      if (csr_read) begin
        case (csr_address)
          2'd0:    csr_readdata_reg <= 32'(level);
          2'd1:    csr_readdata_reg <= wr_retired_reg;
          2'd2:    csr_readdata_reg <= rd_done_reg;
          default: csr_readdata_reg <= max_fill_reg;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Randomised bench: a CPU-side driver, a memory-side slave model and an in-order
// scoreboard of posted writes, plus an architectural memory for read data.
module tb_mem_write_buffer;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 16;

  typedef struct packed {
    logic        rd;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } op_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  csr_address = 2'd0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_readdata;

  mem_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();
  mem_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) m_bus ();

  mem_write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s            (s_bus),
    .m            (m_bus),
    .csr_address  (csr_address),
    .csr_read     (csr_read),
    .csr_write    (csr_write),
    .csr_readdata (csr_readdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] slave_mem [NWORDS];
  logic [31:0] arch_mem  [NWORDS];
  op_t         sb [$];
  op_t         plan [$];
  op_t         op;
  bit          busy = 0, random_en = 0, force_stall = 0, csr_en = 0, abort = 0;
  bit          csr_pend = 0;
  logic [31:0] csr_exp;
  logic [1:0]  csr_sel;
  int          age = 0, stall_pct = 0;
  int unsigned exp_retired = 0, exp_reads = 0, exp_max = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic drive();
    if (!busy) begin
      if (plan.size() > 0) begin
        op = plan.pop_front(); busy = 1; age = 0;
      end else if (random_en) begin
        op.rd = ($urandom_range(0, 3) == 0);
        op.a  = {26'd0, 4'($urandom_range(0, NWORDS-1)), 2'b00};
        op.d  = $urandom;
        op.be = 4'($urandom_range(1, 15));
        busy = 1; age = 0;
      end
    end
    s_bus.write      = busy && !op.rd;
    s_bus.read       = busy && op.rd;
    s_bus.address    = op.a;
    s_bus.writedata  = op.d;
    s_bus.byteenable = op.be;
    m_bus.waitrequest = force_stall || ($urandom_range(0, 99) < stall_pct);
    csr_read    = ($urandom_range(0, 3) == 0);
    csr_address = 2'($urandom_range(0, 3));
    csr_write   = csr_en && ($urandom_range(0, 24) == 0);
    #1 m_bus.readdata = slave_mem[m_bus.address[5:2]];
  endtask

  task automatic observe();
    op_t w;
    @(negedge clk);
    if (csr_pend) begin
      check_val($sformatf("csr%0d", csr_sel), csr_readdata, csr_exp);
      csr_pend = 0;
    end
    if (csr_read) begin
      csr_pend = 1;
      csr_sel  = csr_address;
      case (csr_address)
        2'd0:    csr_exp = 32'(sb.size());
        2'd1:    csr_exp = exp_retired;
        2'd2:    csr_exp = exp_reads;
        default: csr_exp = exp_max;
      endcase
    end
    check_val("wr_rd_excl", 32'(m_bus.write && m_bus.read), 32'd0);
    if (m_bus.read) check_val("rd_behind_wr", 32'(sb.size()), 32'd0);
    else            check_val("m_write_lvl", 32'(m_bus.write), 32'(sb.size() != 0));

    if (busy && !op.rd) begin
      check_val("s_wait_wr", 32'(s_bus.waitrequest), 32'(sb.size() >= DEPTH));
      if (!s_bus.waitrequest) begin
        sb.push_back(op);
        arch_mem[op.a[5:2]] = merge(arch_mem[op.a[5:2]], op.d, op.be);
        $display("WR a=%h d=%h be=%h", op.a, op.d, op.be);
        busy = 0;
      end
    end else if (busy && op.rd && !s_bus.waitrequest) begin
      check_val("rd_data", s_bus.readdata, arch_mem[op.a[5:2]]);
      $display("RD a=%h d=%h", op.a, s_bus.readdata);
      exp_reads++;
      busy = 0;
    end

    if (m_bus.write && !m_bus.waitrequest) begin
      if (sb.size() == 0) check_val("spurious_wr", 32'd1, 32'd0);
      else begin
        w = sb.pop_front();
        check_val("m_addr", m_bus.address, w.a);
        check_val("m_data", m_bus.writedata, w.d);
        check_val("m_be", 32'(m_bus.byteenable), 32'(w.be));
        slave_mem[w.a[5:2]] = merge(slave_mem[w.a[5:2]], w.d, w.be);
        exp_retired++;
      end
    end

    if (32'(sb.size()) > exp_max) exp_max = 32'(sb.size());
    if (csr_write) begin
      exp_retired = 0; exp_reads = 0; exp_max = 0;
    end

    if (busy) begin
      age++;
      if (age > 400) begin
        check_val("timeout", 32'(age), 32'd400);
        abort = 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n && !abort; c++) begin
      @(posedge clk);
      #1;
      drive();
      observe();
    end
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) begin
      slave_mem[i] = '0;
      arch_mem[i]  = '0;
    end
    op = '0;
    s_bus.write = 0; s_bus.read = 0; s_bus.address = '0;
    s_bus.writedata = '0; s_bus.byteenable = '0;
    m_bus.waitrequest = 0; m_bus.readdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_s_wait", 32'(s_bus.waitrequest), 32'd1);
    check_val("rst_m_write", 32'(m_bus.write), 32'd0);
    check_val("rst_m_read", 32'(m_bus.read), 32'd0);
    @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check_val("rst_s_rdata", s_bus.readdata, 32'd0);
    check_val("rst_csr_rdata", csr_readdata, 32'd0);

    // In-order retirement with a free-running memory, then a full FIFO behind a stall.
    for (int i = 0; i < 4; i++) plan.push_back('{1'b0, 32'h10 + 32'(4*i), 32'(i+1), 4'hF});
    run(8);
    force_stall = 1;
    for (int i = 0; i < 5; i++) plan.push_back('{1'b0, 32'h20 + 32'(4*i), 32'hA0 + 32'(i), 4'hF});
    run(10);
    force_stall = 0;
    run(12);

    // Two writes behind a stall, then a read that must wait for the drain.
    force_stall = 1;
    plan.push_back('{1'b0, 32'h30, 32'hDEADBEEF, 4'hF});
    plan.push_back('{1'b0, 32'h34, 32'h12345678, 4'hF});
    plan.push_back('{1'b1, 32'h30, 32'h0, 4'hF});
    run(5);
    force_stall = 0;
    run(15);

    csr_en = 1;
    random_en = 1;
    stall_pct = 0;  run(400);
    stall_pct = 50; run(500);
    stall_pct = 85; run(500);

    // Reset while writes are buffered and a read is waiting in DRAIN.
    random_en = 0;
    force_stall = 1;
    for (int i = 0; i < 3; i++) plan.push_back('{1'b0, 32'h00 + 32'(4*i), 32'hC0 + 32'(i), 4'hF});
    plan.push_back('{1'b1, 32'h04, 32'h0, 4'hF});
    run(8);
    @(posedge clk);
    #1 reset_n = 0;
    csr_read = 0; csr_write = 0;
    @(negedge clk);
    check_val("mid_rst_s_wait", 32'(s_bus.waitrequest), 32'd1);
    check_val("mid_rst_m_write", 32'(m_bus.write), 32'd0);
    check_val("mid_rst_m_read", 32'(m_bus.read), 32'd0);
    @(posedge clk);
    #1 reset_n = 1;
    busy = 0; csr_pend = 0; force_stall = 0;
    s_bus.write = 0; s_bus.read = 0;
    m_bus.waitrequest = 0;
    csr_read = 1; csr_address = 2'd0;
    @(negedge clk);
    check_val("post_rst_m_write", 32'(m_bus.write), 32'd0);
    check_val("post_rst_m_read", 32'(m_bus.read), 32'd0);
    check_val("post_rst_csr_rdata", csr_readdata, 32'd0);
    @(posedge clk);
    #1 csr_read = 0;
    @(negedge clk);
    check_val("post_rst_csr0", csr_readdata, 32'd0);
    sb.delete();
    exp_retired = 0; exp_reads = 0; exp_max = 0;
    for (int i = 0; i < NWORDS; i++) arch_mem[i] = slave_mem[i];

    random_en = 1;
    stall_pct = 40; run(400);

    // Drain everything and confirm memory matches the CPU's view.
    random_en = 0; csr_en = 0; stall_pct = 0;
    run(40);
    check_val("drain_idle", 32'(busy), 32'd0);
    check_val("drain_empty", 32'(sb.size()), 32'd0);
    for (int i = 0; i < NWORDS; i++) check_val($sformatf("mem%0d", i), slave_mem[i], arch_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
